nes_mmc1_set: RTL



---
 rtl/nes_mmc1_set.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nes_mmc1_set.sv
// Cartridge mapper block: MMC1 serial-register banking for PRG flash and CHR SRAM,
// or fixed NROM mapping when MMC_FUNC selects anything other than mapper 1.
module nes_mmc1_set #(
  parameter logic [7:0]  MMC_FUNC    = 8'h01,
  parameter int          PRG_BANKS   = 16,
  parameter int          CHR_BANKS   = 32,
  parameter logic [22:0] PRG_BASE    = 23'h0,
  parameter logic [2:0]  NROM_MIRROR = 3'h2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_bus_addr,
  input  logic [7:0]  i_bus_wdata,
  input  logic        i_bus_r_wn,
  output logic [7:0]  o_mmc_rdata,
  output logic [22:0] o_fl_addr,
  input  logic [7:0]  i_fl_rdata,
  input  logic        i_ppu_a12,
  output logic [7:0]  o_sram_addr_ext,
  output logic [2:0]  o_mirror_mode,
  output logic        o_irq_n
);

  localparam bit         IS_MMC1  = (MMC_FUNC == 8'h01);
  localparam logic [3:0] PRG_MASK = 4'(PRG_BANKS - 1);
  localparam logic [4:0] CHR_MASK = 5'(CHR_BANKS - 1);
  localparam logic [3:0] PRG_LAST = 4'(PRG_BANKS - 1);

  logic       hit;
  logic       regw;
  logic       regw_d;
  logic       wstb;
  logic [4:0] shift_in;

  logic [4:0] shift_q, shift_d;
  logic [2:0] count_q, count_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;

  logic [3:0]  prg_bank;
  logic [17:0] prg_off;
  logic [22:0] mmc1_fl_addr;
  logic [22:0] nrom_fl_addr;
  logic [4:0]  chr_bank;

  // Bits that are stored or presented on the bus but never drive an output.
  logic unused_bits;
  assign unused_bits = ^{i_bus_wdata[6:1], prg_q[4]};

  assign hit      = i_bus_addr[15];
  assign regw     = hit & ~i_bus_r_wn;
  // A write held over several cycles, or repeated without an idle cycle, is one event.
  assign wstb     = regw & ~regw_d;
  assign shift_in = {i_bus_wdata[0], shift_q[4:1]};

  // Serial register load: four shifts, the fifth write commits to the addressed register.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    ctrl_d  = ctrl_q;
    chr0_d  = chr0_q;
    chr1_d  = chr1_q;
    prg_d   = prg_q;
    if (IS_MMC1 && wstb) begin
      if (i_bus_wdata[7]) begin
        shift_d = 5'h00;
        count_d = 3'd0;
        ctrl_d  = ctrl_q | 5'h0C;
      end else if (count_q < 3'd4) begin
        shift_d = shift_in;
        count_d = count_q + 3'd1;
      end else begin
        shift_d = 5'h00;
        count_d = 3'd0;
        case (i_bus_addr[14:13])
          2'd0:    ctrl_d = shift_in;
          2'd1:    chr0_d = shift_in;
          2'd2:    chr1_d = shift_in;
          default: prg_d  = shift_in;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      regw_d  <= 1'b0;
      shift_q <= 5'h00;
      count_q <= 3'd0;
      ctrl_q  <= 5'h0C;
      chr0_q  <= 5'h00;
      chr1_q  <= 5'h00;
      prg_q   <= 5'h00;
    end else begin
      regw_d  <= regw;
      shift_q <= shift_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      chr0_q  <= chr0_d;
      chr1_q  <= chr1_d;
      prg_q   <= prg_d;
    end
  end

  // PRG bank select: ctrl[3:2] picks 32KB mode, fixed-low or fixed-high 16KB mode.
  always_comb begin
    prg_bank = 4'h0;
    case (ctrl_q[3:2])
      2'd0, 2'd1: prg_bank = {prg_q[3:1], i_bus_addr[14]};
      2'd2:       prg_bank = i_bus_addr[14] ? prg_q[3:0] : 4'h0;
      default:    prg_bank = i_bus_addr[14] ? PRG_LAST : prg_q[3:0];
    endcase
  end

  assign prg_off      = {prg_bank & PRG_MASK, i_bus_addr[13:0]};
  assign mmc1_fl_addr = PRG_BASE + 23'(prg_off);
  assign nrom_fl_addr = PRG_BASE + 23'(i_bus_addr[14:0]);

  always_comb begin
    o_fl_addr = 23'h0;
    if (hit) o_fl_addr = IS_MMC1 ? mmc1_fl_addr : nrom_fl_addr;
  end

  assign o_mmc_rdata = hit ? i_fl_rdata : 8'h00;

  // CHR: 8KB mode pairs chr0 with A12, 4KB mode switches between chr0 and chr1.
  always_comb begin
    chr_bank = 5'h00;
    if (ctrl_q[4]) chr_bank = i_ppu_a12 ? chr1_q : chr0_q;
    else           chr_bank = {chr0_q[4:1], i_ppu_a12};
  end

  assign o_sram_addr_ext = IS_MMC1 ? {3'b000, chr_bank & CHR_MASK} : {7'h00, i_ppu_a12};
  assign o_mirror_mode   = IS_MMC1 ? {1'b0, ctrl_q[1:0]} : NROM_MIRROR;
  assign o_irq_n         = 1'b1;

endmodule
